// File: rtl/spi_master_seq_if.sv
// Command/response bundle between the host logic and the SPI command sequencer.
// master: host side driving commands; slave: the sequencer accepting them.
interface spi_master_seq_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              busy;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, rsp_valid, rsp_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, rsp_valid, rsp_data, busy
   );
endinterface

// File: rtl/spi_master_seq.sv
// SPI command sequencer: serialises (op, byte) commands into SS_n/MOSI frames, returns MISO bytes.
// Define SPI_MST_SKID_EN to add a one-entry command buffer that chains frames without an IDLE cycle.
module spi_master_seq #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned RD_LAT  = 2,
   parameter int unsigned GAP_CYC = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   spi_master_seq_if.slave bus,
   output logic            o_ss_n,
   output logic            o_mosi,
   input  logic            i_miso
);
   localparam int unsigned FRAME_W = DATA_W + 2;
   localparam int unsigned MAX_A   = (FRAME_W > RD_LAT) ? FRAME_W : RD_LAT;
   localparam int unsigned CNT_MAX = (MAX_A > GAP_CYC) ? MAX_A : GAP_CYC;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_SHIFT = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_RECV  = 3'd4;
   localparam logic [2:0] S_GUARD = 3'd5;

   logic [2:0]         r_state, w_state_d;
   logic [CNT_W-1:0]   r_cnt, w_cnt_d;
   logic [FRAME_W-1:0] r_shreg, w_shreg_d;
   logic               r_rd, w_rd_d;
   logic [DATA_W-2:0]  r_rx, w_rx_d;
   logic [DATA_W-1:0]  w_rx_full;
   logic               r_ss_n, r_mosi, r_busy, r_cmd_ready, r_rsp_valid, w_rsp_valid_d;
   logic [DATA_W-1:0]  r_rsp_data, w_rsp_data_d;
   logic               w_accept, w_load;
   logic [FRAME_W-1:0] w_cmd, w_load_val;
`ifdef SPI_MST_SKID_EN
   logic [FRAME_W-1:0] r_buf, w_buf_d;
   logic               r_buf_full, w_buf_full_d;
   logic               w_take_in;
`endif

   assign w_cmd     = {bus.cmd_op, bus.cmd_data};
   assign w_accept  = bus.cmd_valid && r_cmd_ready;
   assign w_rx_full = {r_rx, i_miso};

   always_comb begin
      w_state_d     = r_state;
      w_cnt_d       = r_cnt;
      w_shreg_d     = r_shreg;
      w_rd_d        = r_rd;
      w_rx_d        = r_rx;
      w_rsp_valid_d = 1'b0;
      w_rsp_data_d  = r_rsp_data;
      w_load        = 1'b0;
      w_load_val    = w_cmd;
`ifdef SPI_MST_SKID_EN
      w_buf_d       = r_buf;
      w_buf_full_d  = r_buf_full;
      w_take_in     = 1'b0;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_load = 1'b1;
`ifdef SPI_MST_SKID_EN
               w_take_in = 1'b1;
`endif
            end
         end
         S_START: begin
            w_state_d = S_SHIFT;
            w_cnt_d   = CNT_W'(FRAME_W - 1);
         end
         S_SHIFT: begin
            w_shreg_d = r_shreg << 1;
            if (r_cnt == '0) begin
               if (!r_rd) begin
                  w_state_d = S_GUARD;
                  w_cnt_d   = CNT_W'(GAP_CYC - 1);
               end else if (RD_LAT != 0) begin
                  w_state_d = S_WAIT;
                  w_cnt_d   = CNT_W'(RD_LAT - 1);
               end else begin
                  w_state_d = S_RECV;
                  w_cnt_d   = CNT_W'(DATA_W - 1);
               end
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state_d = S_RECV;
               w_cnt_d   = CNT_W'(DATA_W - 1);
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         S_RECV: begin
            w_rx_d = w_rx_full[DATA_W-2:0];
            if (r_cnt == '0) begin
               w_rsp_valid_d = 1'b1;
               w_rsp_data_d  = w_rx_full;
               w_state_d     = S_GUARD;
               w_cnt_d       = CNT_W'(GAP_CYC - 1);
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         S_GUARD: begin
            if (r_cnt == '0) begin
`ifdef SPI_MST_SKID_EN
               // Chain straight into START; a command offered now bypasses the empty buffer.
               if (r_buf_full) begin
                  w_load       = 1'b1;
                  w_load_val   = r_buf;
                  w_buf_full_d = 1'b0;
               end else if (w_accept) begin
                  w_load    = 1'b1;
                  w_take_in = 1'b1;
               end else begin
                  w_state_d = S_IDLE;
               end
`else
               w_state_d = S_IDLE;
`endif
            end else begin
               w_cnt_d = r_cnt - 1'b1;
            end
         end
         default: w_state_d = S_IDLE;
      endcase
`ifdef SPI_MST_SKID_EN
      if (w_accept && !w_take_in) begin
         w_buf_d      = w_cmd;
         w_buf_full_d = 1'b1;
      end
`endif
      if (w_load) begin
         w_state_d = S_START;
         w_shreg_d = w_load_val;
         w_rd_d    = (w_load_val[FRAME_W-1 -: 2] == 2'b11);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_shreg     <= '0;
         r_rd        <= 1'b0;
         r_rx        <= '0;
         r_ss_n      <= 1'b1;
         r_mosi      <= 1'b0;
         r_busy      <= 1'b0;
         r_cmd_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_state     <= w_state_d;
         r_cnt       <= w_cnt_d;
         r_shreg     <= w_shreg_d;
         r_rd        <= w_rd_d;
         r_rx        <= w_rx_d;
         // Outputs are registered from the next state so they line up with the state register.
         r_ss_n      <= (w_state_d == S_IDLE) || (w_state_d == S_GUARD);
         r_mosi      <= (w_state_d == S_SHIFT) && w_shreg_d[FRAME_W-1];
         r_busy      <= (w_state_d != S_IDLE);
`ifdef SPI_MST_SKID_EN
         r_cmd_ready <= !w_buf_full_d;
`else
         r_cmd_ready <= (w_state_d == S_IDLE);
`endif
         r_rsp_valid <= w_rsp_valid_d;
         r_rsp_data  <= w_rsp_data_d;
      end
   end

`ifdef SPI_MST_SKID_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf      <= '0;
         r_buf_full <= 1'b0;
      end else begin
         r_buf      <= w_buf_d;
         r_buf_full <= w_buf_full_d;
      end
   end
`endif

   assign o_ss_n        = r_ss_n;
   assign o_mosi        = r_mosi;
   assign bus.busy      = r_busy;
   assign bus.cmd_ready = r_cmd_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_spi_master_seq.sv
// Bench for spi_master_seq: a per-cycle waveform model built from frame rules, plus directed literals.
// Honours SPI_MST_SKID_EN when the design is built with it.
module tb_spi_master_seq;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned RD_LAT  = 2;
   localparam int unsigned GAP_CYC = 1;

   logic clk;
   logic rst_n;
   logic miso;
   logic ss_n;
   logic mosi;

   spi_master_seq_if #(.DATA_W(DATA_W)) bus_if ();

   spi_master_seq #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT),
      .GAP_CYC(GAP_CYC)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if),
      .o_ss_n(ss_n),
      .o_mosi(mosi),
      .i_miso(miso)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One entry per expected cycle of a frame; empty queue means idle.
   typedef struct packed {
      logic              ss_n;
      logic              mosi;
      logic              rv;
      logic              recv;
      logic              miso;
      logic [DATA_W-1:0] rd;
   } ent_t;

   ent_t              m_q[$];
   logic              m_buf_full;
   logic [1:0]        m_buf_op;
   logic [DATA_W-1:0] m_buf_data;
   logic [DATA_W-1:0] m_rsp;
   logic              m_rdy, m_acc;
   int                m_acc_cnt;
   int                cyc;
   logic              force_en;
   logic [DATA_W-1:0] force_rb;
   int                n_checks;
   int                n_errors;
   int                t_acc;
   ent_t              c_e;

   logic prev_ss;
   int   cur_len, last_len, hi_cnt, last_gap, n_rsp, last_rsp_cyc;
   logic [31:0] cur_bits, last_bits;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic logic model_ready();
`ifdef SPI_MST_SKID_EN
      return !m_buf_full;
`else
      return m_q.size() == 0;
`endif
   endfunction

   function automatic void push_frame(input logic [1:0] op, input logic [DATA_W-1:0] data);
      logic [DATA_W+1:0] bits;
      logic [DATA_W-1:0] rb;
      ent_t e;
      bits   = {op, data};
      rb     = force_en ? force_rb : DATA_W'($urandom);
      e.ss_n = 1'b0;
      e.mosi = 1'b0;
      e.rv   = 1'b0;
      e.recv = 1'b0;
      e.miso = 1'b0;
      e.rd   = rb;
      m_q.push_back(e);
      for (int i = DATA_W + 1; i >= 0; i--) begin
         e.mosi = bits[i];
         m_q.push_back(e);
      end
      e.mosi = 1'b0;
      if (op == 2'b11) begin
         for (int i = 0; i < int'(RD_LAT); i++) m_q.push_back(e);
         e.recv = 1'b1;
         for (int i = DATA_W - 1; i >= 0; i--) begin
            e.miso = rb[i];
            m_q.push_back(e);
         end
         e.recv = 1'b0;
         e.miso = 1'b0;
      end
      e.ss_n = 1'b1;
      for (int g = 0; g < int'(GAP_CYC); g++) begin
         e.rv = (op == 2'b11) && (g == 0);
         m_q.push_back(e);
      end
   endfunction

   function automatic void model_reset();
      m_q.delete();
      m_buf_full = 1'b0;
      m_rsp      = '0;
   endfunction

   // Model advances on every active edge using the inputs presented during the ending cycle.
   initial begin
      cyc = 0;
      m_acc_cnt = 0;
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (rst_n) begin
            m_rdy = model_ready();
            m_acc = bus_if.cmd_valid && m_rdy;
            if (m_q.size() > 0) m_q.delete(0);
            if (m_acc) m_acc_cnt++;
            if (m_q.size() == 0) begin
               if (m_buf_full) begin
                  push_frame(m_buf_op, m_buf_data);
                  m_buf_full = 1'b0;
               end else if (m_acc) begin
                  push_frame(bus_if.cmd_op, bus_if.cmd_data);
               end
            end else if (m_acc) begin
               m_buf_op   = bus_if.cmd_op;
               m_buf_data = bus_if.cmd_data;
               m_buf_full = 1'b1;
            end
            if (m_q.size() > 0 && m_q[0].rv) m_rsp = m_q[0].rd;
         end
      end
   end

   // Slave stand-in: reply bits during RECV, noise elsewhere.
   initial begin
      miso = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (m_q.size() > 0 && m_q[0].recv) miso = m_q[0].miso;
         else miso = 1'($urandom);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (m_q.size() > 0) c_e = m_q[0];
         else begin
            c_e = '0;
            c_e.ss_n = 1'b1;
         end
         chk("ss_n", 32'(ss_n), 32'(c_e.ss_n));
         chk("mosi", 32'(mosi), 32'(c_e.mosi));
         chk("busy", 32'(bus_if.busy), 32'(m_q.size() != 0));
         chk("cmd_ready", 32'(bus_if.cmd_ready), 32'(model_ready()));
         chk("rsp_valid", 32'(bus_if.rsp_valid), 32'(c_e.rv));
         chk("rsp_data", 32'(bus_if.rsp_data), 32'(m_rsp));
      end
   end

   // Frame monitor: SS_n-low run length, MOSI trace, SS_n-high gap, response timing.
   initial begin
      prev_ss = 1'b1;
      cur_len = 0; last_len = 0; hi_cnt = 0; last_gap = 0; n_rsp = 0; last_rsp_cyc = 0;
      cur_bits = '0; last_bits = '0;
      forever begin
         @(negedge clk);
         if (ss_n === 1'b0) begin
            if (prev_ss) begin
               cur_len  = 0;
               cur_bits = '0;
               last_gap = hi_cnt;
            end
            cur_len++;
            cur_bits = {cur_bits[30:0], mosi};
         end else begin
            if (!prev_ss) begin
               last_len  = cur_len;
               last_bits = cur_bits;
               hi_cnt    = 0;
            end
            hi_cnt++;
         end
         prev_ss = (ss_n !== 1'b0);
         if (bus_if.rsp_valid === 1'b1) begin
            n_rsp++;
            last_rsp_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Holds the command until the model accepts it; leaves cmd_valid high for the caller.
   task automatic send(input logic [1:0] op, input logic [DATA_W-1:0] d);
      int a0;
      a0 = m_acc_cnt;
      bus_if.cmd_valid = 1'b1;
      bus_if.cmd_op    = op;
      bus_if.cmd_data  = d;
      for (int i = 0; i < 100 && m_acc_cnt == a0; i++) tick();
      if (m_acc_cnt == a0) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got no acceptance, expected one within 100 cycles");
      end
      t_acc = cyc - 1;
   endtask

   task automatic wait_idle();
      int i;
      bus_if.cmd_valid = 1'b0;
      for (i = 0; i < 200 && (m_q.size() != 0 || m_buf_full); i++) tick();
      if (i == 200) begin
         n_checks++;
         n_errors++;
         $display("FAIL idle_timeout: got busy model, expected idle within 200 cycles");
      end
      tick();
      tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      n_checks = 0;
      n_errors = 0;
      force_en = 1'b0;
      force_rb = '0;
      bus_if.cmd_valid = 1'b0;
      bus_if.cmd_op    = 2'b00;
      bus_if.cmd_data  = '0;
      rst_n = 1'b1;
      #2;
      rst_n = 1'b0;
      model_reset();
      repeat (5) @(posedge clk);
      #1;
      chk("reset_ss_n", 32'(ss_n), 32'd1);
      chk("reset_mosi", 32'(mosi), 32'd0);
      chk("reset_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
      chk("reset_busy", 32'(bus_if.busy), 32'd0);
      chk("reset_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
      chk("reset_rsp_data", 32'(bus_if.rsp_data), 32'd0);
      rst_n = 1'b1;
      tick();

      // wr-addr 0x3A: START 0 then 00_00111010.
      r0 = n_rsp;
      send(2'b00, 8'h3A);
      wait_idle();
      chk("wr_ss_low_len", 32'(last_len), 32'd11);
      chk("wr_mosi_bits", last_bits & 32'h7FF, 32'h03A);
      chk("wr_no_rsp", 32'(n_rsp - r0), 32'd0);

      // rd-data with 0xA5 returned: response 22 cycles after the handshake cycle.
      r0 = n_rsp;
      force_en = 1'b1;
      force_rb = 8'hA5;
      send(2'b11, 8'h00);
      force_en = 1'b0;
      wait_idle();
      chk("rd_rsp_data", 32'(bus_if.rsp_data), 32'hA5);
      chk("rd_rsp_count", 32'(n_rsp - r0), 32'd1);
      chk("rd_rsp_latency", 32'(last_rsp_cyc - t_acc), 32'd22);
      chk("rd_ss_low_len", 32'(last_len), 32'd21);

      // Back-to-back wr-addr then wr-data 0x5C.
      send(2'b00, 8'h3A);
      send(2'b01, 8'h5C);
      wait_idle();
`ifdef SPI_MST_SKID_EN
      chk("b2b_gap", 32'(last_gap), 32'(GAP_CYC));
`else
      chk("b2b_gap", 32'(last_gap), 32'(GAP_CYC + 1));
`endif
      chk("b2b_ss_low_len", 32'(last_len), 32'd11);
      chk("b2b_mosi_bits", last_bits & 32'h7FF, 32'h15C);

      // Reset asserted during SHIFT bit 4.
      send(2'b01, 8'hC3);
      bus_if.cmd_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_pre_ss_n", 32'(ss_n), 32'd0);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst_ss_n", 32'(ss_n), 32'd1);
      chk("midrst_busy", 32'(bus_if.busy), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("midrst_ready", 32'(bus_if.cmd_ready), 32'd1);
      send(2'b10, 8'h7E);
      wait_idle();
      chk("postrst_ss_low_len", 32'(last_len), 32'd11);
      chk("postrst_mosi_bits", last_bits & 32'h7FF, 32'h27E);

      // Random traffic; inputs wander freely even while not offered.
      for (int i = 0; i < 4000; i++) begin
         bus_if.cmd_valid = ($urandom % 3) == 0;
         bus_if.cmd_op    = 2'($urandom);
         bus_if.cmd_data  = DATA_W'($urandom);
         tick();
      end
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
